elh_tag_encoder: RTL and testbench
==================================

Name: elh_tag_encoder

Overview:
- Inverse of the ELH bounds decoder.
- Takes an allocation (24-bit start address, byte size) and searches for the unique ELH tag whose decoded alloc region matches the allocation exactly.
- Used by the allocator/tagging path before tagged pointers are issued.
- Iterative: tests one exponent per cycle, with valid/ready request and response handshakes.

Parameters:
- ADDR_W, 24, address width. The tag layout fixes this at 24; other values are unsupported.
- MAX_E, 24, last exponent step searched.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset. One clock; reset is synchronous and active-high.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  encoder idle, can accept a request.
- req_start_i  input  24  allocation start address.
- req_size_i  input  25  allocation size in bytes, 1..2^24.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_tag_o  output  8  ELH tag. Layout: [7:6]=e[4:3], [5:4]=L, [3]=H, [2:0]=e[2:0].
- rsp_err_o  output  1  no exact encoding exists, or the request is illegal.

Behaviour:
- States: IDLE, SEARCH, DONE.
- Reset (any state, including mid-SEARCH or DONE): state=IDLE, rsp_valid_o=0, rsp_tag_o=8'h00, rsp_err_o=0, e counter=0. Any pending request or result is dropped.
- req_ready_o = (state==IDLE). Handshake when req_valid_i & req_ready_o in cycle T; start and size are registered.
- Illegal request in the accept cycle goes straight to DONE; rsp_valid_o=1 at T+1 with err=1 and tag=0. Illegal means any of:
  - size==0
  - size>2^24
  - start+size>2^24 (25-bit sum)
- Legal request: SEARCH from T+1 with e_q=0. Each SEARCH cycle evaluates e_q as follows:
  - Block count n = size>>e_q. Requires size[e_q-1:0]==0.
  - off = start mod (base*2^e_q). Requires start mod 2^e_q == 0.
- e_q<22, match table (n, base, offset in blocks -> L,H):
  - n=1, base 1, off 0 -> L0 H1
  - n=3, base 4, off 0 -> L1 H1; off 1 -> L1 H0
  - n=5, base 8, off 0 -> L2 H1; off 3 -> L2 H0
  - n=7, base 8, off 0 -> L3 H1; off 1 -> L3 H0
  - Tag e field = e_q.
- e_q=22, tag e field = 22:
  - n=1 -> L0 H1
  - n=3, base 4, off 0 -> L2 H1; off 1 -> L2 H0
- e_q=23, n=1 -> e=22, L1 H1.
- e_q=24, n=1, start==0 -> e=22, L3 H1.
- Any other combination is no match.
- At most one (e, L, H) matches exactly, so the result does not depend on search order.
- Match at e_q=k, or e_q==MAX_E without a match: go to DONE.
  - rsp_valid_o rises at T+2+k.
  - Failure without early exit: rsp_valid_o at T+26, err=1, tag=0.
- DONE: rsp_valid_o, rsp_tag_o and rsp_err_o held stable until rsp_ready_i. On the handshake cycle, next state is IDLE, rsp_valid_o=0, tag/err cleared.
- req_ready_o stays low in SEARCH and DONE. There is no request overlap; the next accept is earliest the cycle after the response handshake.
- A successful tag is never 8'h00. It always round-trips through the decoder to alloc_start=req_start and alloc_end=req_start+size-1.

Optional Feature:
- Macro: ELH_ENC_EARLY_EXIT_EN.
- Defined: in SEARCH, if (size>>e_q)==0 and there is no match, go to DONE with err=1, tag=0. Failure latency becomes T+2+e_q, where e_q = floor(log2 size)+1.
- Undefined: failures always run to e_q=24 and respond at T+26.
- Success latency and results are identical either way.

Test Plan:
- start=0x000100, size=0x10 -> tag=0x0C, err=0, rsp_valid at T+6. Also start=0x000050, size=0x30 -> tag=0x14 at T+6.
- start=0x000040, size=0x30 -> tag=0x1C. start=0x000300, size=0x500 -> tag=0x60 at T+10.
- start=0x800000, size=0x800000 -> tag=0x9E at T+25. start=0, size=0x1000000 -> tag=0xBE at T+26.
- start=0, size=0x9:
  - Macro off: err=1, tag=0x00 at T+26.
  - Macro on: err=1 at T+6.
  - Also size=0, or start=0xFFFFF0 with size=0x20 -> err=1 at T+1.
- Backpressure: hold rsp_ready_i=0 for 3 cycles after rsp_valid -> tag/err stable and req_ready_o=0. Handshake -> req_ready_o=1 the next cycle, and a back-to-back request is accepted.
- Assert rst_i mid-SEARCH (e_q=5) -> next cycle rsp_valid_o=0, req_ready_o=1, tag=0x00. A fresh request then completes normally.

Source files
------------

// File: rtl/elh_tag_encoder.sv
// Iterative ELH tag encoder: finds the tag whose decoded region equals (start, size), one exponent per cycle.
// Optional macro ELH_ENC_EARLY_EXIT_EN: stop the search with an error once size>>e reaches zero.
module elh_tag_encoder #(
  parameter int ADDR_W = 24,
  parameter int MAX_E  = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_start_i,
  input  logic [ADDR_W:0]   req_size_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_tag_o,
  output logic              rsp_err_o
);

  localparam int SW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        e_q, e_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [SW-1:0]     size_q, size_d;
  logic [7:0]        tag_q, tag_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;

  // Returns {hit, L[1:0], H} for one exponent step.
  function automatic logic [3:0] match_lh(input logic [4:0] e,
                                          input logic [SW-1:0] size,
                                          input logic [ADDR_W-1:0] start);
    logic [SW-1:0] n;
    logic [SW-1:0] mask;
    logic [2:0]    blk;
    logic [3:0]    r;
    r    = 4'b0000;
    n    = size >> e;
    mask = ~({SW{1'b1}} << e);
    blk  = 3'(start >> e);
    if (((size & mask) == '0) && ((start & mask[ADDR_W-1:0]) == '0)) begin
      if (e < 5'd22) begin
        if (n == SW'(1))                          r = 4'b1001;
        else if (n == SW'(3) && blk[1:0] == 2'd0) r = 4'b1011;
        else if (n == SW'(3) && blk[1:0] == 2'd1) r = 4'b1010;
        else if (n == SW'(5) && blk == 3'd0)      r = 4'b1101;
        else if (n == SW'(5) && blk == 3'd3)      r = 4'b1100;
        else if (n == SW'(7) && blk == 3'd0)      r = 4'b1111;
        else if (n == SW'(7) && blk == 3'd1)      r = 4'b1110;
      end else if (e == 5'd22) begin
        if (n == SW'(1))                          r = 4'b1001;
        else if (n == SW'(3) && blk[1:0] == 2'd0) r = 4'b1101;
        else if (n == SW'(3) && blk[1:0] == 2'd1) r = 4'b1100;
      end else if (e == 5'd23) begin
        if (n == SW'(1))                          r = 4'b1011;
      end else if (e == 5'd24) begin
        if (n == SW'(1) && start == '0)           r = 4'b1111;
      end
    end
    return r;
  endfunction

  logic [ADDR_W+1:0] sum_w;
  logic              illegal_w;
  logic [3:0]        m_w;
  logic [4:0]        ef_w;

  always_comb begin
    sum_w     = {2'b00, req_start_i} + {1'b0, req_size_i};
    illegal_w = (req_size_i == '0) ||
                ({1'b0, req_size_i} > ((ADDR_W+2)'(1) << ADDR_W)) ||
                (sum_w > ((ADDR_W+2)'(1) << ADDR_W));
    m_w  = match_lh(e_q, size_q, start_q);
    ef_w = (e_q < 5'd22) ? e_q : 5'd22;
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    start_d = start_q;
    size_d  = size_q;
    tag_d   = tag_q;
    err_d   = err_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          start_d = req_start_i;
          size_d  = req_size_i;
          if (illegal_w) begin
            state_d = DONE;
            vld_d   = 1'b1;
            err_d   = 1'b1;
            tag_d   = 8'h00;
          end else begin
            state_d = SEARCH;
            e_d     = 5'd0;
          end
        end
      end
      SEARCH: begin
        if (m_w[3]) begin
          state_d = DONE;
          vld_d   = 1'b1;
          err_d   = 1'b0;
          tag_d   = {ef_w[4:3], m_w[2:1], m_w[0], ef_w[2:0]};
        end else if (e_q == 5'(MAX_E)
`ifdef ELH_ENC_EARLY_EXIT_EN
                     || ((size_q >> e_q) == '0)
`endif
                    ) begin
          state_d = DONE;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          tag_d   = 8'h00;
        end else begin
          e_d = e_q + 5'd1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          err_d   = 1'b0;
          tag_d   = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      e_q     <= 5'd0;
      tag_q   <= 8'h00;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // Request operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk_i) begin
    start_q <= start_d;
    size_q  <= size_d;
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = vld_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_elh_tag_encoder.sv
// Scoreboard bench for elh_tag_encoder: driver queues expected responses, negedge monitor compares them.
module tb_elh_tag_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_start_i;
  logic [24:0] req_size_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [7:0]  rsp_tag_o;
  logic        rsp_err_o;

  elh_tag_encoder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_start_i (req_start_i),
    .req_size_i  (req_size_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef ELH_ENC_EARLY_EXIT_EN
  localparam int FAIL9_LAT  = 6;
  localparam int FAIL48_LAT = 8;
`else
  localparam int FAIL9_LAT  = 26;
  localparam int FAIL48_LAT = 26;
`endif

  typedef struct {
    logic [7:0] tag;
    logic       err;
    int         lat;
    int         t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 0;
  int   first = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: pop one expectation per response handshake.
  always @(negedge clk_i) begin
    exp_t x;
    if (rst_i) begin
      seen = 0;
    end else begin
      if (rsp_valid_o && !seen) begin
        seen  = 1;
        first = cyc;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        seen = 0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag 0x%0h err %0d expected no response", rsp_tag_o, rsp_err_o);
        end else begin
          x = q.pop_front();
          chk("rsp_tag", int'(rsp_tag_o), int'(x.tag));
          chk("rsp_err", int'(rsp_err_o), int'(x.err));
          chk("rsp_latency", first - x.t, x.lat);
        end
      end
    end
  end

  task automatic send(input logic [23:0] s, input logic [24:0] z, input logic [7:0] et,
                      input logic ee, input int el, input bit push);
    int   n;
    exp_t x;
    n = 0;
    req_start_i = s;
    req_size_i  = z;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got ready 0 expected 1");
    end else if (push) begin
      x.tag = et;
      x.err = ee;
      x.lat = el;
      x.t   = cyc;
      q.push_back(x);
    end
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_start_i = '0;
    req_size_i  = '0;
    rsp_ready_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    chk("reset_state", int'({rsp_valid_o, req_ready_o, rsp_err_o, rsp_tag_o}), int'({1'b0, 1'b1, 1'b0, 8'h00}));

    send(24'h000100, 25'h10,      8'h0C, 1'b0, 6,  1); wait_idle();
    send(24'h000050, 25'h30,      8'h14, 1'b0, 6,  1); wait_idle();
    send(24'h000040, 25'h30,      8'h1C, 1'b0, 6,  1); wait_idle();
    send(24'h000300, 25'h500,     8'h60, 1'b0, 10, 1); wait_idle();
    send(24'h000005, 25'h1,       8'h08, 1'b0, 2,  1); wait_idle();
    send(24'h800000, 25'h800000,  8'h9E, 1'b0, 25, 1); wait_idle();
    send(24'h400000, 25'hC00000,  8'hA6, 1'b0, 24, 1); wait_idle();
    send(24'h000000, 25'h1000000, 8'hBE, 1'b0, 26, 1); wait_idle();
    send(24'h000000, 25'h9,       8'h00, 1'b1, FAIL9_LAT,  1); wait_idle();
    send(24'h000020, 25'h30,      8'h00, 1'b1, FAIL48_LAT, 1); wait_idle();
    send(24'h000000, 25'h0,       8'h00, 1'b1, 1, 1); wait_idle();
    send(24'hFFFFF0, 25'h20,      8'h00, 1'b1, 1, 1); wait_idle();
    send(24'h000000, 25'h1000001, 8'h00, 1'b1, 1, 1); wait_idle();

    // Backpressure: response must hold for three cycles, then a back-to-back request follows.
    rsp_ready_i = 1'b0;
    send(24'h000100, 25'h10, 8'h0C, 1'b0, 6, 1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_stable", int'({rsp_valid_o, req_ready_o, rsp_err_o, rsp_tag_o}), int'({1'b1, 1'b0, 1'b0, 8'h0C}));
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("ready_after_hs", int'({rsp_valid_o, req_ready_o}), int'({1'b0, 1'b1}));
    send(24'h000040, 25'h30, 8'h1C, 1'b0, 6, 1);
    wait_idle();

    // Reset during SEARCH at e=5 drops the request.
    send(24'h800000, 25'h800000, 8'h00, 1'b0, 0, 0);
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_search_reset", int'({rsp_valid_o, req_ready_o, rsp_err_o, rsp_tag_o}), int'({1'b0, 1'b1, 1'b0, 8'h00}));
    send(24'h000300, 25'h500, 8'h60, 1'b0, 10, 1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
